// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types, defaults and the cyclic-priority search used by the RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_BURST = 4;
    localparam int MAX_REQ   = 32;

    typedef logic [$clog2(DEF_NREQ)-1:0] req_idx_t;

    // First set bit of req[n-1:0] searching upward from ptr with wraparound; 0 when none set.
    function automatic int rr_first(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
        logic [MAX_REQ-1:0] r;
        int m;
        rr_first = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            m = (ptr + k) % n;
            r = req >> m;
            if (k < n && r[0]) rr_first = m;
        end
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational cyclic priority picker starting at ptr.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        idx = IW'(rr_first(MAX_REQ'(req), NREQ, int'(ptr)));
        any = |req;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of a synchronous-read RAM between NREQ requesters,
// with bounded bursts and a one-cycle grant-to-rvalid latency.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = DEF_BURST
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        grant,
    output logic [ADDR_W-1:0]      ram_addr,
    input  logic [DATA_W-1:0]      ram_read,
    output logic [DATA_W-1:0]      rdata,
    output logic [NREQ-1:0]        rvalid
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST - 1);

    logic [IW-1:0] ptr, owner, cand, gidx;
    logic [CW-1:0] count;
    logic          owner_valid, cand_any, others, keep, gany;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .idx (cand),
        .any (cand_any)
    );

    // Owner holds the bus until its burst saturates while someone else is waiting.
    always_comb begin
        others   = |(req & ~(NREQ'(1) << owner));
        keep     = owner_valid & req[owner] & ((count < CMAX) | !others);
        gidx     = keep ? owner : cand;
        gany     = reset_n & enable & (keep | cand_any);
        grant    = gany ? NREQ'(1) << gidx : '0;
        ram_addr = gany ? addr[gidx*ADDR_W +: ADDR_W] : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            count       <= '0;
            rvalid      <= '0;
        end else begin
            rvalid <= grant;
            if (gany) begin
                count       <= (owner_valid && gidx == owner) ? ((count == CMAX) ? count : count + 1'b1) : '0;
                owner       <= gidx;
                owner_valid <= 1'b1;
                ptr         <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end else begin
                owner_valid <= 1'b0;
                count       <= '0;
            end
        end
    end

    assign rdata = ram_read;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors with hand-computed grant/address/rvalid/rdata expectations.
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [31:0] addr = {16'd1, 16'd0};
    logic [1:0]  grant;
    logic [15:0] ram_addr;
    logic [15:0] ram_read = 16'h0;
    logic [15:0] rdata;
    logic [1:0]  rvalid;
    logic [15:0] mem [4];
    int nvec = 0;
    int nerr = 0;

    ram_arbiter dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .req      (req),
        .addr     (addr),
        .grant    (grant),
        .ram_addr (ram_addr),
        .ram_read (ram_read),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    always #5 clock = ~clock;

    initial begin
        mem[0] = 16'hff00;
        mem[1] = 16'h0f0f;
        mem[2] = 16'h0000;
        mem[3] = 16'h0000;
    end

    always @(posedge clock) ram_read <= mem[ram_addr[1:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Apply one cycle of inputs, check that cycle's outputs, then advance one clock.
    task automatic vec(input string tag, input logic en, input logic [1:0] r,
                       input logic [1:0] eg, input logic [15:0] ea,
                       input logic [1:0] erv, input logic [15:0] erd);
        enable = en;
        req = r;
        #1;
        check({tag, ".grant"}, grant, eg);
        check({tag, ".ram_addr"}, ram_addr, ea);
        check({tag, ".rvalid"}, rvalid, erv);
        if (erv != 2'b00) check({tag, ".rdata"}, rdata, erd);
        tick();
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        enable = 1'b0;
        req = 2'b00;
        #1;
        check("rst.grant", grant, 2'b00);
        check("rst.rvalid", rvalid, 2'b00);
        check("rst.ram_addr", ram_addr, 16'h0);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        tick();
        do_reset();
        // Single read: grant now, data and rvalid next cycle.
        vec("t1.c0", 1'b1, 2'b01, 2'b01, 16'h0, 2'b00, 16'h0);
        vec("t1.c1", 1'b1, 2'b00, 2'b00, 16'h0, 2'b01, 16'hff00);
        // Two contending requesters: bursts of four, alternating.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            logic [1:0] g, gp;
            g  = ((k / 4) % 2 == 1) ? 2'b10 : 2'b01;
            gp = (k == 0) ? 2'b00 : ((((k - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01);
            vec($sformatf("t2.c%0d", k), 1'b1, 2'b11, g, (g == 2'b10) ? 16'h1 : 16'h0,
                gp, (gp == 2'b10) ? 16'h0f0f : 16'hff00);
        end
        // Lone requester saturates; a newcomer after saturation gets the bus at once.
        do_reset();
        vec("t3.c0", 1'b1, 2'b01, 2'b01, 16'h0, 2'b00, 16'h0);
        for (int k = 1; k < 5; k++)
            vec($sformatf("t3.c%0d", k), 1'b1, 2'b01, 2'b01, 16'h0, 2'b01, 16'hff00);
        vec("t3.c5", 1'b1, 2'b11, 2'b10, 16'h1, 2'b01, 16'hff00);
        vec("t3.c6", 1'b1, 2'b11, 2'b10, 16'h1, 2'b10, 16'h0f0f);
        // Owner 1 drops req mid-burst: requester 0 granted in the same cycle.
        vec("t4.c0", 1'b1, 2'b01, 2'b01, 16'h0, 2'b10, 16'h0f0f);
        vec("t4.c1", 1'b1, 2'b01, 2'b01, 16'h0, 2'b01, 16'hff00);
        // Enable dropped mid-burst, then restored: restart from ptr=1.
        do_reset();
        vec("t5.c0", 1'b1, 2'b11, 2'b01, 16'h0, 2'b00, 16'h0);
        vec("t5.c1", 1'b1, 2'b11, 2'b01, 16'h0, 2'b01, 16'hff00);
        vec("t5.c2", 1'b0, 2'b11, 2'b00, 16'h0, 2'b01, 16'hff00);
        vec("t5.c3", 1'b0, 2'b11, 2'b00, 16'h0, 2'b00, 16'h0);
        vec("t5.c4", 1'b0, 2'b11, 2'b00, 16'h0, 2'b00, 16'h0);
        vec("t5.c5", 1'b1, 2'b11, 2'b10, 16'h1, 2'b00, 16'h0);
        vec("t5.c6", 1'b1, 2'b11, 2'b10, 16'h1, 2'b10, 16'h0f0f);
        // Asynchronous reset mid-burst clears outputs between edges; ptr back to 0.
        vec("t6.c0", 1'b1, 2'b11, 2'b10, 16'h1, 2'b10, 16'h0f0f);
        reset_n = 1'b0;
        #1;
        check("t6.async.grant", grant, 2'b00);
        check("t6.async.rvalid", rvalid, 2'b00);
        check("t6.async.ram_addr", ram_addr, 16'h0);
        tick();
        reset_n = 1'b1;
        vec("t6.c1", 1'b1, 2'b11, 2'b01, 16'h0, 2'b00, 16'h0);
        vec("t6.c2", 1'b1, 2'b11, 2'b01, 16'h0, 2'b01, 16'hff00);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port, read-only, synchronous-read code/data RAM (1-cycle read latency) between NREQ requesters, e.g. core instruction fetch and display fetch.
- Round-robin arbitration with bounded bursts: the owner keeps the bus for up to MAX_BURST consecutive reads while others wait.
- Sits between the requesters and the RAM slave. Drives the RAM address and returns read data plus a per-requester valid.

Parameters:
NREQ, 2, number of requesters (>=2)
ADDR_W, 16, RAM address width
DATA_W, 16, RAM data width
MAX_BURST, 4, max consecutive grants to one owner while another requester waits (>=1)

Ports:
clock  input  1  single clock; all state on posedge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  arbitration enable (from core control "running"); low = no new grants
req  input  NREQ  per-requester read request, level, held until granted
addr  input  NREQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W]
grant  output  NREQ  one-hot or zero; grant[i]=1 means addr[i] is presented to RAM this cycle
ram_addr  output  ADDR_W  address to RAM slave
ram_read  input  DATA_W  RAM read data, valid one cycle after address
rdata  output  DATA_W  broadcast read data (= ram_read)
rvalid  output  NREQ  rvalid[i]=1 means rdata belongs to requester i (grant[i] delayed 1 cycle)

Behaviour:
- State: ptr (rotating priority index), owner, owner_valid, count (0..MAX_BURST-1, saturating), rvalid register.
- Reset (reset_n low, async): ptr=0, owner=0, owner_valid=0, count=0, rvalid=0. grant=0 and ram_addr=0 while reset_n is low.
- cand: first i with req[i]=1, searching cyclically from ptr.
- others: any req[j]=1 with j!=owner.
- keep = owner_valid & req[owner] & (count < MAX_BURST-1 | !others).
- gidx = keep ? owner : cand. gany = enable & (keep | |req).
- grant = gany ? onehot(gidx) : 0, combinational. ram_addr = addr[gidx] when gany, else 0.
- On posedge when gany:
  - same owner continuing (owner_valid & gidx==owner): count = min(count+1, MAX_BURST-1).
  - otherwise: count=0.
  - owner=gidx, owner_valid=1, ptr=(gidx+1) mod NREQ.
- On posedge when !gany: owner_valid=0, count=0, ptr unchanged.
- rvalid <= grant every cycle, so read latency is exactly 1 cycle from grant to rvalid. rdata = ram_read, combinational passthrough.
- Handover has no bubble: the cycle the owner is denied, the next requester is granted.
- Owner dropping req releases immediately; cand is granted the same cycle.
- A lone requester keeps the bus indefinitely with count saturated.
- enable falls mid-burst: grant=0 in the same cycle. The rvalid for the previous cycle's grant is still delivered. owner_valid clears.
- enable rises: arbitration restarts from the current ptr.
- req without enable: never granted. rvalid stays 0 one cycle later.
- MAX_BURST=1: strict alternation whenever more than one requester is active.
- Throughput: one read per cycle.
- No combinational path from ram_read to grant.

Decomposition:
- Package ram_arb_pkg:
  - typedef req_idx_t (width $clog2(NREQ)).
  - function rr_first(req, ptr) returning index.
  - constant default burst 4.
- Sub-module rr_pick: combinational cyclic priority picker.
  - Inputs: req, ptr.
  - Outputs: idx, any.
- Integration: wraps the existing ram_bus slave. ram_addr drives bus.addr; bus.read drives ram_read.

Test Plan:
1. Reset, then enable=1 with req=2'b01, addr0=0 for 1 cycle -> grant=01, ram_addr=0. Next cycle rvalid=01, rdata='hff00 (RAM holds {'hff00,'h0f0f}).
2. req=2'b11, addr0=0, addr1=1, held, MAX_BURST=4, ptr=0 -> grant sequence 01,01,01,01,10,10,10,10,01...; rvalid follows 1 cycle later; rdata alternates 'hff00 x4 then 'h0f0f x4.
3. req0 alone for 10 cycles -> grant=01 every cycle, count saturates at 3. Assert req1 at cycle 5 -> req0 keeps at most 3 more cycles; no bubble at handover.
4. Burst in progress, owner req1 drops while req0 high -> grant switches to 01 the same cycle; no idle cycle on ram_addr.
5. req=11, enable dropped mid-burst -> grant=0 the same cycle; rvalid for the last grant still fires once; no further rvalid until enable=1.
6. reset_n pulsed low mid-burst (asynchronous, between edges) -> grant, rvalid, ptr immediately 0. After release with req=11 -> requester 0 is granted first.
